// File: rtl/nios_led_nios2_qsys_0_oci_dct_sequencer.sv
// Trace atom compression sequencer: packs 2-bit atoms into a 15-slot buffer,
// launches full/flushed/drained buffers to a held output frame, and runs the end-of-test drain.
module nios_led_nios2_qsys_0_oci_dct_sequencer #(
  parameter int IDLE_FLUSH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_enable,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush_req,
  input  logic        test_ending,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frm_valid,
  output logic [29:0] frm_data,
  output logic [3:0]  frm_count,
  input  logic        frm_ready,
  output logic        test_has_ended,
  output logic        overflow
);

  localparam int IDLE_W = $clog2(IDLE_FLUSH + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_FLUSH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    ENDED   = 2'd2
  } state_t;

  state_t state, state_next;

  logic              flush_pend, flush_pend_next;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_next;
  logic [29:0]       buf_next;
  logic [3:0]        count_next;

  logic atom_offered;
  logic accept;
  logic buf_full;
  logic buf_empty;
  logic slot_free;
  logic launch_cond;
  logic launch;
  logic idle_cycle;
  logic idle_hit;
  logic flush_set;
  logic drop;

  assign buf_full     = (dct_count == 4'd15);
  assign buf_empty    = (dct_count == 4'd0);
  assign atom_offered = atom_valid & (atom != 2'b00);

  assign atom_ready = (state == COLLECT) & trc_enable & ~buf_full & ~flush_pend;
  assign accept     = atom_offered & atom_ready;
  assign drop       = (state == COLLECT) & trc_enable & atom_offered & ~atom_ready;

  assign slot_free   = ~frm_valid | frm_ready;
  assign launch_cond = buf_full
                     | (flush_pend & ~buf_empty)
                     | ((state == DRAIN) & ~buf_empty);
  assign launch      = launch_cond & slot_free;

  // An idle cycle is one where a partial buffer sits in COLLECT without growing.
  assign idle_cycle = (state == COLLECT) & ~buf_empty & ~accept;
  assign idle_hit   = idle_cycle & (idle_cnt == IDLE_LAST);
  assign flush_set  = (flush_req & (state != ENDED) & (~buf_empty | accept)) | idle_hit;

  assign test_has_ended = (state == ENDED);

  always_comb begin
    buf_next   = dct_buffer;
    count_next = dct_count;
    if (launch) begin
      buf_next   = '0;
      count_next = '0;
    end else if (accept) begin
      buf_next[{dct_count, 1'b0} +: 2] = atom;
      count_next = dct_count + 4'd1;
    end
  end

  always_comb begin
    idle_cnt_next = idle_cnt;
    if (accept || launch) begin
      idle_cnt_next = '0;
    end else if (idle_cycle && (idle_cnt != IDLE_MAX)) begin
      idle_cnt_next = idle_cnt + IDLE_W'(1);
    end
  end

  // A launch consumes the buffer being flushed, so it always wins over a new request.
  always_comb begin
    flush_pend_next = flush_pend | flush_set;
    if (launch) begin
      flush_pend_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (test_ending) state_next = DRAIN;
      DRAIN:   if (buf_empty && !frm_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      dct_buffer <= buf_next;
      dct_count  <= count_next;
      flush_pend <= flush_pend_next;
      idle_cnt   <= idle_cnt_next;
      overflow   <= overflow | drop;
    end
  end

  // Output slot reloads directly when a handshake and a launch share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_valid <= 1'b0;
      frm_data  <= '0;
      frm_count <= '0;
    end else if (launch) begin
      frm_valid <= 1'b1;
      frm_data  <= dct_buffer;
      frm_count <= dct_count;
    end else if (frm_ready) begin
      frm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_led_nios2_qsys_0_oci_dct_sequencer.sv
// Directed self-checking bench for the DCT sequencer: full frames, flushes,
// back-pressure overflow, idle auto-flush, end-of-test drain and async reset.
module tb_nios_led_nios2_qsys_0_oci_dct_sequencer;

  logic        clk;
  logic        reset;
  logic        trc_enable;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush_req;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frm_valid;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic        frm_ready;
  logic        test_has_ended;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  nios_led_nios2_qsys_0_oci_dct_sequencer #(.IDLE_FLUSH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .trc_enable     (trc_enable),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frm_valid      (frm_valid),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .frm_ready      (frm_ready),
    .test_has_ended (test_has_ended),
    .overflow       (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers one atom only once the sequencer is ready, so waiting never looks like a drop.
  task automatic applyStimulus(input logic [1:0] code);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!atom_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!atom_ready) begin
      checkOutput("atom_ready_timeout", 32'(atom_ready), 32'd1);
    end else begin
      atom_valid = 1'b1;
      atom       = code;
      @(posedge clk);
      #1;
      atom_valid = 1'b0;
      atom       = 2'b00;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    reset       = 1'b1;
    trc_enable  = 1'b0;
    atom_valid  = 1'b0;
    atom        = 2'b00;
    flush_req   = 1'b0;
    test_ending = 1'b0;
    frm_ready   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_dct_count", 32'(dct_count), 32'd0);
    checkOutput("rst_frm_valid", 32'(frm_valid), 32'd0);
    checkOutput("rst_ended", 32'(test_has_ended), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    reset      = 1'b0;
    trc_enable = 1'b1;

    // Fifteen taken atoms fill the buffer and launch on the following edge.
    for (int i = 0; i < 15; i++) applyStimulus(2'b10);
    checkOutput("full_count", 32'(dct_count), 32'd15);
    checkOutput("full_no_frame_yet", 32'(frm_valid), 32'd0);
    stepEdge();
    checkOutput("full_frm_valid", 32'(frm_valid), 32'd1);
    checkOutput("full_frm_data", 32'(frm_data), 32'h2AAAAAAA);
    checkOutput("full_frm_count", 32'(frm_count), 32'd15);
    checkOutput("full_dct_count", 32'(dct_count), 32'd0);
    stepEdge();
    checkOutput("full_pulse_end", 32'(frm_valid), 32'd0);

    // Reserved code, disabled tracing and an empty flush must all be no-ops.
    pulseReset();
    atom_valid = 1'b1;
    atom       = 2'b00;
    stepEdge();
    atom_valid = 1'b0;
    checkOutput("code00_ignored", 32'(dct_count), 32'd0);
    @(negedge clk);
    trc_enable = 1'b0;
    atom_valid = 1'b1;
    atom       = 2'b11;
    stepEdge();
    atom_valid = 1'b0;
    trc_enable = 1'b1;
    checkOutput("disabled_ignored", 32'(dct_count), 32'd0);
    checkOutput("disabled_no_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    flush_req = 1'b1;
    stepEdge();
    flush_req = 1'b0;
    stepEdge();
    checkOutput("empty_flush_noop", 32'(frm_valid), 32'd0);

    // Three mixed atoms then an explicit flush.
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    @(negedge clk);
    flush_req = 1'b1;
    stepEdge();
    flush_req = 1'b0;
    checkOutput("flush_pending_ready", 32'(atom_ready), 32'd0);
    stepEdge();
    checkOutput("flush_frm_valid", 32'(frm_valid), 32'd1);
    checkOutput("flush_frm_data", 32'(frm_data), 32'h39);
    checkOutput("flush_frm_count", 32'(frm_count), 32'd3);
    checkOutput("flush_dct_count", 32'(dct_count), 32'd0);

    // Back-pressure: one held frame plus a full buffer, then a dropped atom.
    pulseReset();
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(2'b01);
    for (int i = 0; i < 15; i++) applyStimulus(2'b11);
    checkOutput("bp_no_drop_yet", 32'(overflow), 32'd0);
    @(negedge clk);
    checkOutput("bp_atom_ready", 32'(atom_ready), 32'd0);
    atom_valid = 1'b1;
    atom       = 2'b10;
    stepEdge();
    atom_valid = 1'b0;
    checkOutput("bp_overflow", 32'(overflow), 32'd1);
    checkOutput("bp_frm_valid", 32'(frm_valid), 32'd1);
    checkOutput("bp_frm_data_held", 32'(frm_data), 32'h15555555);
    checkOutput("bp_frm_count_held", 32'(frm_count), 32'd15);
    checkOutput("bp_buffer", 32'(dct_buffer), 32'h3FFFFFFF);
    @(negedge clk);
    frm_ready = 1'b1;
    stepEdge();
    checkOutput("reload_frm_valid", 32'(frm_valid), 32'd1);
    checkOutput("reload_frm_data", 32'(frm_data), 32'h3FFFFFFF);
    checkOutput("reload_dct_count", 32'(dct_count), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // One atom, then the idle counter forces a flush 65 edges later.
    pulseReset();
    frm_ready = 1'b1;
    applyStimulus(2'b01);
    cycles = 0;
    for (int i = 1; i <= 80; i++) begin
      stepEdge();
      if (frm_valid) begin
        cycles = i;
        break;
      end
    end
    checkOutput("idle_launch_edge", 32'(cycles), 32'd65);
    checkOutput("idle_frm_count", 32'(frm_count), 32'd1);
    checkOutput("idle_frm_data", 32'(frm_data), 32'h1);

    // End-of-test drain with a held frame, then ENDED ignores atoms.
    pulseReset();
    frm_ready = 1'b0;
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    @(negedge clk);
    test_ending = 1'b1;
    stepEdge();
    checkOutput("drain_atom_ready", 32'(atom_ready), 32'd0);
    stepEdge();
    test_ending = 1'b0;
    checkOutput("drain_frm_valid", 32'(frm_valid), 32'd1);
    checkOutput("drain_frm_count", 32'(frm_count), 32'd5);
    checkOutput("drain_frm_data", 32'(frm_data), 32'h1B6);
    stepEdge();
    checkOutput("drain_not_ended", 32'(test_has_ended), 32'd0);
    @(negedge clk);
    frm_ready = 1'b1;
    stepEdge();
    checkOutput("drain_handshake", 32'(frm_valid), 32'd0);
    checkOutput("drain_ended_early", 32'(test_has_ended), 32'd0);
    stepEdge();
    checkOutput("ended", 32'(test_has_ended), 32'd1);
    @(negedge clk);
    checkOutput("ended_atom_ready", 32'(atom_ready), 32'd0);
    atom_valid = 1'b1;
    atom       = 2'b10;
    flush_req  = 1'b1;
    stepEdge();
    atom_valid = 1'b0;
    flush_req  = 1'b0;
    stepEdge();
    checkOutput("ended_count", 32'(dct_count), 32'd0);
    checkOutput("ended_no_frame", 32'(frm_valid), 32'd0);
    checkOutput("ended_no_ovf", 32'(overflow), 32'd0);
    checkOutput("ended_hold", 32'(test_has_ended), 32'd1);

    // Reset mid-buffer with a held frame clears everything before the next edge.
    pulseReset();
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(2'b11);
    for (int i = 0; i < 7; i++) applyStimulus(2'b10);
    checkOutput("mid_count", 32'(dct_count), 32'd7);
    checkOutput("mid_frame_held", 32'(frm_valid), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_dct_count", 32'(dct_count), 32'd0);
    checkOutput("async_dct_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("async_frm_valid", 32'(frm_valid), 32'd0);
    checkOutput("async_frm_data", 32'(frm_data), 32'd0);
    checkOutput("async_frm_count", 32'(frm_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
